// File: rtl/regbank_apb_if.sv
// APB bus bundle between the interconnect (master) and the register bank (slave).
interface regbank_apb_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/regbank_apb.sv
// Parametrised APB register bank with RW / RO / W1C registers, byte strobes,
// programmable wait states and error responses. Register contents are exported
// flat for block logic; RO values and W1C set requests come from hardware.
//
// The setup phase is recognised directly from psel & !penable while the FSM is
// idle, so the controller moves straight to ACCESS on the setup edge and the
// wait counter is loaded there. With no wait states pready is already high in
// the first access cycle, giving a two-cycle transfer and allowing a new setup
// immediately after each completion.
module regbank_apb #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  // reg i lives in bits [i*DATA_WIDTH +: DATA_WIDTH]
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES =
    {32'd0, 32'd0, 32'd0, 32'd12, 32'd1, 32'd1, 32'd1, 32'd0},
  parameter logic [NUM_REGS-1:0] RESET_MASK = 8'b1001_1111,
  // two bits per register: 0 = RW, 1 = RO, 2 = W1C, 3 = illegal
  parameter logic [NUM_REGS*2-1:0] ACCESS = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  regbank_apb_if.slave                   apb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] hw_regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o,
  output logic [NUM_REGS-1:0]            rd_pulse_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);
  localparam logic READY_AT_LOAD = (WAIT_STATES == 0);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                  state_reg;
  logic [2:0]              wait_cnt_reg;
  logic                    pready_reg;
  logic [NUM_REGS-1:0]     wr_pulse_reg;
  logic [NUM_REGS-1:0]     rd_pulse_reg;

  logic [NUM_REGS-1:0]     sel;
  logic [NUM_REGS-1:0]     ro_mask;
  logic [DATA_WIDTH-1:0]   byte_mask;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    setup_phase;
  logic                    complete;
  logic                    addr_ok;
  logic                    wr_err;
  logic                    xfer_err;
  logic                    wr_fire;

  // Inputs whose slices are ignored for some access types are folded here.
  logic                    unused_hw;
  assign unused_hw = ^{hw_ro_i, hw_set_i};

  assign setup_phase = apb.psel && !apb.penable;
  assign complete    = (state_reg == S_ACCESS) && pready_reg && apb.psel && apb.penable;
  assign addr_ok     = {1'b0, apb.paddr} < NUM_REGS_W;
  assign wr_err      = apb.pwrite && (|(sel & ro_mask));
  assign xfer_err    = !addr_ok || wr_err;
  assign wr_fire     = complete && apb.pwrite && !xfer_err;

  // Byte strobes expanded to a bit mask.
  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
    assign byte_mask[gi*8 +: 8] = {8{apb.pstrb[gi]}};
  end

  // Per-register decode, storage and export.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [1:0] ACC = ACCESS[gi*2 +: 2];
    // Illegal code 3 behaves as read-only so a bus write can never corrupt it.
    localparam logic IS_RO  = ACC[0];
    localparam logic IS_W1C = (ACC == 2'd2);

    assign sel[gi]     = (apb.paddr == ADDR_WIDTH'(gi));
    assign ro_mask[gi] = IS_RO;

    if (IS_RO) begin : g_ro
      assign hw_regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = hw_ro_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_store
      logic [DATA_WIDTH-1:0] q_reg;
      logic [DATA_WIDTH-1:0] q_next;

      // Next value: bus write on completion, then hardware set for W1C (set wins).
      always_comb begin
        q_next = q_reg;
        if (wr_fire && sel[gi]) begin
          if (IS_W1C) begin
            q_next = q_reg & ~(apb.pwdata & byte_mask);
          end else begin
            q_next = (q_reg & ~byte_mask) | (apb.pwdata & byte_mask);
          end
        end
        if (IS_W1C) begin
          q_next = q_next | hw_set_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      if (RESET_MASK[gi]) begin : g_rst
        // Register with reset to its programmed value.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            q_reg <= RESET_VALUES[gi*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            q_reg <= q_next;
          end
        end
      end else begin : g_nrst
        // Register without reset: retains its contents across reset.
        always_ff @(posedge clk) begin
          q_reg <= q_next;
        end
      end

      assign hw_regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
    end
  end

  // Read mux over the exported contents (RO slices already carry hw_ro_i).
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) begin
        rd_mux = hw_regs_o[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transfer FSM with wait counter, registered pready and access pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      pready_reg   <= 1'b0;
      wr_pulse_reg <= '0;
      rd_pulse_reg <= '0;
    end else begin
      wr_pulse_reg <= '0;
      rd_pulse_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          // A lone penable without a setup phase is ignored here.
          if (setup_phase) begin
            state_reg    <= S_ACCESS;
            wait_cnt_reg <= WAIT_LOAD;
            pready_reg   <= READY_AT_LOAD;
          end
        end
        S_ACCESS: begin
          if (!apb.psel) begin
            // Master abandoned the transfer: no write, no pulse.
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            pready_reg   <= 1'b0;
          end else if (!apb.penable) begin
            // A fresh setup phase restarts the transfer.
            wait_cnt_reg <= WAIT_LOAD;
            pready_reg   <= READY_AT_LOAD;
          end else if (!pready_reg) begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
            pready_reg   <= (wait_cnt_reg == 3'd1);
          end else begin
            state_reg  <= S_IDLE;
            pready_reg <= 1'b0;
            if (!xfer_err) begin
              if (apb.pwrite) begin
                wr_pulse_reg <= sel;
              end else begin
                rd_pulse_reg <= sel;
              end
            end
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          pready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign apb.pready  = pready_reg;
  assign apb.pslverr = complete && xfer_err;
  assign apb.prdata  = (complete && !apb.pwrite && addr_ok) ? rd_mux : '0;
  assign wr_pulse_o  = wr_pulse_reg;
  assign rd_pulse_o  = rd_pulse_reg;

endmodule

// File: tb/tb_regbank_apb.sv
// Directed bench for regbank_apb: a default-parameter bank (a) and a
// six-register bank with wait states, RO and W1C registers (b).
module tb_regbank_apb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic tgt, psel, penable, pwrite;
  logic [2:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  regbank_apb_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus_a ();
  regbank_apb_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus_b ();

  assign bus_a.psel    = psel & ~tgt;
  assign bus_a.penable = penable;
  assign bus_a.pwrite  = pwrite;
  assign bus_a.paddr   = paddr;
  assign bus_a.pwdata  = pwdata;
  assign bus_a.pstrb   = pstrb;
  assign bus_b.psel    = psel & tgt;
  assign bus_b.penable = penable;
  assign bus_b.pwrite  = pwrite;
  assign bus_b.paddr   = paddr;
  assign bus_b.pwdata  = pwdata;
  assign bus_b.pstrb   = pstrb;

  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;
  assign pready_m  = tgt ? bus_b.pready  : bus_a.pready;
  assign pslverr_m = tgt ? bus_b.pslverr : bus_a.pslverr;
  assign prdata_m  = tgt ? bus_b.prdata  : bus_a.prdata;

  logic [255:0] hw_ro_a, hw_set_a, hw_regs_a;
  logic [7:0]   wr_pulse_a, rd_pulse_a;
  logic [191:0] hw_ro_b, hw_set_b, hw_regs_b;
  logic [5:0]   wr_pulse_b, rd_pulse_b;

  regbank_apb dut_a (
    .clk(clk), .reset(rst_a), .apb(bus_a),
    .hw_ro_i(hw_ro_a), .hw_set_i(hw_set_a), .hw_regs_o(hw_regs_a),
    .wr_pulse_o(wr_pulse_a), .rd_pulse_o(rd_pulse_a)
  );

  regbank_apb #(
    .NUM_REGS(6), .WAIT_STATES(3), .RESET_VALUES(192'd0),
    .RESET_MASK(6'b111111), .ACCESS(12'h060)   // reg3 RO, reg2 W1C
  ) dut_b (
    .clk(clk), .reset(rst_b), .apb(bus_b),
    .hw_ro_i(hw_ro_b), .hw_set_i(hw_set_b), .hw_regs_o(hw_regs_b),
    .wr_pulse_o(wr_pulse_b), .rd_pulse_o(rd_pulse_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer; returns read data, error and rising edges used.
  task automatic xfer(input logic t, input logic wr, input logic [2:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int cycles);
    logic done;
    int n;
    tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb;
    rdata = '0; err = 1'b0; done = 1'b0;
    tick();
    penable = 1'b1;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      if (pready_m) begin
        done = 1'b1;
        rdata = prdata_m;
        err = pslverr_m;
      end
      tick();
      n++;
    end
    cycles = n;
    psel = 1'b0;
    penable = 1'b0;
    check("xfer_done", 32'(done), 32'd1);
  endtask

  logic seen;
  task automatic mon_cycle();
    @(negedge clk);
    seen = seen | pready_m | (|wr_pulse_b);
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc, c1, c2;
  logic [31:0] exp_rst [8];

  initial begin
    exp_rst = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd12, 32'd0, 32'd0, 32'd0};
    tgt = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    hw_ro_a = '0; hw_set_a = '0; hw_ro_b = '0; hw_set_b = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("rst_pready",   32'(bus_a.pready), 32'd0);
    check("rst_pslverr",  32'(bus_a.pslverr), 32'd0);
    check("rst_prdata",   bus_a.prdata, 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse_a), 32'd0);
    check("rst_rd_pulse", 32'(rd_pulse_a), 32'd0);
    check("rst_reg4",     hw_regs_a[4*32 +: 32], 32'd12);
    check("rst_pready_b", 32'(bus_b.pready), 32'd0);
    @(posedge clk);
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Reset value readback
    for (int i = 0; i < 8; i++) begin
      if (i != 5 && i != 6) begin
        xfer(1'b0, 1'b0, 3'(i), 32'd0, 4'hF, rd, er, cyc);
        check($sformatf("rst_rd%0d", i), rd, exp_rst[i]);
        check($sformatf("rst_err%0d", i), 32'(er), 32'd0);
      end
    end

    // Unreset registers survive a second reset
    xfer(1'b0, 1'b1, 3'd5, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
    check("wr5_pulse", 32'(wr_pulse_a), 32'h20);
    xfer(1'b0, 1'b1, 3'd6, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
    xfer(1'b0, 1'b1, 3'd0, 32'h00000055, 4'hF, rd, er, cyc);
    rst_a = 1'b1;
    tick();
    tick();
    check("reg5_in_rst", hw_regs_a[5*32 +: 32], 32'hA5A5A5A5);
    rst_a = 1'b0;
    tick();
    xfer(1'b0, 1'b0, 3'd5, 32'd0, 4'hF, rd, er, cyc);
    check("reg5_kept", rd, 32'hA5A5A5A5);
    xfer(1'b0, 1'b0, 3'd6, 32'd0, 4'hF, rd, er, cyc);
    check("reg6_kept", rd, 32'hA5A5A5A5);
    xfer(1'b0, 1'b0, 3'd0, 32'd0, 4'hF, rd, er, cyc);
    check("reg0_reset", rd, 32'd0);

    // Byte strobes
    xfer(1'b0, 1'b1, 3'd1, 32'hDEADBEEF, 4'b0101, rd, er, cyc);
    check("strb_err", 32'(er), 32'd0);
    check("strb_pulse", 32'(wr_pulse_a), 32'h02);
    tick();
    check("strb_pulse_end", 32'(wr_pulse_a), 32'h00);
    xfer(1'b0, 1'b0, 3'd1, 32'd0, 4'hF, rd, er, cyc);
    check("strb_rd", rd, 32'h00AD00EF);
    check("rd1_pulse", 32'(rd_pulse_a), 32'h02);

    // Zero strobe write: no change, still pulses
    xfer(1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'h0, rd, er, cyc);
    check("strb0_err", 32'(er), 32'd0);
    check("strb0_pulse", 32'(wr_pulse_a), 32'h01);
    xfer(1'b0, 1'b0, 3'd0, 32'd0, 4'hF, rd, er, cyc);
    check("strb0_rd", rd, 32'd0);

    // Back-to-back write then read
    xfer(1'b0, 1'b1, 3'd4, 32'd7, 4'hF, rd, er, c1);
    xfer(1'b0, 1'b0, 3'd4, 32'd0, 4'hF, rd, er, c2);
    check("b2b_rd", rd, 32'd7);
    check("b2b_cycles", 32'(c1 + c2), 32'd4);

    // Wait states: setup edge + 4 access edges
    xfer(1'b1, 1'b1, 3'd0, 32'h11, 4'hF, rd, er, cyc);
    check("ws_cycles", 32'(cyc), 32'd5);
    check("ws_pulse", 32'(wr_pulse_b), 32'h01);
    check("ws_reg0", hw_regs_b[31:0], 32'h11);

    // RO register and address error
    hw_ro_b[3*32 +: 32] = 32'h1234;
    xfer(1'b1, 1'b1, 3'd3, 32'hFFFF, 4'hF, rd, er, cyc);
    check("ro_wr_err", 32'(er), 32'd1);
    check("ro_wr_pulse", 32'(wr_pulse_b), 32'h00);
    check("ro_unchanged", hw_regs_b[3*32 +: 32], 32'h1234);
    xfer(1'b1, 1'b0, 3'd3, 32'd0, 4'hF, rd, er, cyc);
    check("ro_rd", rd, 32'h1234);
    check("ro_rd_err", 32'(er), 32'd0);
    xfer(1'b1, 1'b0, 3'd7, 32'd0, 4'hF, rd, er, cyc);
    check("badaddr_err", 32'(er), 32'd1);
    check("badaddr_rd", rd, 32'd0);
    check("badaddr_pulse", 32'(rd_pulse_b), 32'h00);

    // W1C behaviour
    hw_set_b[2*32 +: 32] = 32'h21;
    tick();
    hw_set_b[2*32 +: 32] = 32'h0;
    xfer(1'b1, 1'b0, 3'd2, 32'd0, 4'hF, rd, er, cyc);
    check("w1c_set", rd, 32'h21);
    xfer(1'b1, 1'b1, 3'd2, 32'h1, 4'hF, rd, er, cyc);
    xfer(1'b1, 1'b0, 3'd2, 32'd0, 4'hF, rd, er, cyc);
    check("w1c_clr", rd, 32'h20);
    hw_set_b[2*32 +: 32] = 32'h20;
    xfer(1'b1, 1'b1, 3'd2, 32'h20, 4'hF, rd, er, cyc);
    hw_set_b[2*32 +: 32] = 32'h0;
    check("w1c_setwins", hw_regs_b[2*32 +: 32], 32'h20);
    xfer(1'b1, 1'b0, 3'd2, 32'd0, 4'hF, rd, er, cyc);
    check("w1c_setwins_rd", rd, 32'h20);

    // psel dropped during wait states
    seen = 1'b0;
    tgt = 1'b1; pwrite = 1'b1; paddr = 3'd1; pwdata = 32'hABCD; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    mon_cycle();
    penable = 1'b1;
    mon_cycle();
    psel = 1'b0; penable = 1'b0;
    repeat (5) mon_cycle();
    check("abort_no_ready", 32'(seen), 32'd0);
    check("abort_no_write", hw_regs_b[1*32 +: 32], 32'd0);

    // Reset during ACCESS, bus left in access phase afterwards
    seen = 1'b0;
    pwdata = 32'h77;
    psel = 1'b1; penable = 1'b0;
    mon_cycle();
    penable = 1'b1;
    mon_cycle();
    rst_b = 1'b1;
    mon_cycle();
    rst_b = 1'b0;
    repeat (5) mon_cycle();
    psel = 1'b0; penable = 1'b0;
    mon_cycle();
    check("rstabort_no_ready", 32'(seen), 32'd0);
    check("rstabort_no_write", hw_regs_b[1*32 +: 32], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regbank_apb.md
# regbank_apb

- Parametrised APB-slave register bank: the synthesizable successor of the generated register package.
- Holds NUM_REGS registers of DATA_WIDTH bits with per-register reset value, reset/no-reset selection and access type (RW, RO, W1C).
- Supports byte strobes and a configurable number of wait states, and reports errors on bad accesses.
- Sits between the bus interconnect and block logic: it exports the register contents flat and takes hardware inputs for RO and W1C registers.

## Interface
- ADDR_WIDTH, 3: word address width; register index = paddr.
- DATA_WIDTH, 32: register and bus width; multiple of 8.
- NUM_REGS, 8: number of registers; 1..2**ADDR_WIDTH.
- WAIT_STATES, 0: extra access-phase cycles before pready; 0..7.
- RESET_VALUES, {0,1,1,1,12,0,0,0} (reg0 first): NUM_REGS*DATA_WIDTH packed reset values.
- RESET_MASK, 8'b1001_1111 (bit i = reg i): 1 = register reset by reset, 0 = unreset (reg5, reg6 by default).
- ACCESS, all RW: NUM_REGS*2 bits per register; 0 = RW, 1 = RO, 2 = W1C, 3 is illegal.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  ADDR_WIDTH  word address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte write strobes.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data; valid only while pready=1 and pwrite=0.
- pslverr  out  1  error, valid only while pready=1.
- hw_ro_i  in  NUM_REGS*DATA_WIDTH  values returned for RO registers.
- hw_set_i  in  NUM_REGS*DATA_WIDTH  per-bit set requests for W1C registers.
- hw_regs_o  out  NUM_REGS*DATA_WIDTH  current register contents.
- wr_pulse_o  out  NUM_REGS  one-cycle pulse after a successful write to reg i.
- rd_pulse_o  out  NUM_REGS  one-cycle pulse after a successful read of reg i.

## Operation
- FSM states:
  - IDLE: psel=1, penable=0 -> SETUP.
  - SETUP: next cycle, psel=1, penable=1 -> ACCESS, and the wait counter loads WAIT_STATES; psel=0 -> IDLE.
  - ACCESS: while counter>0, decrement it with pready=0. When counter=0, pready=1, the transfer completes, and the next state is SETUP if psel=1 and penable=0, else IDLE.
- Protocol violations:
  - penable=1 seen in IDLE is ignored.
  - psel dropping in ACCESS before completion returns to IDLE. No write and no pulse.
- Error (pslverr=1 at completion):
  - paddr>=NUM_REGS, or a write to an RO register.
  - Errored writes change nothing; errored reads return prdata=0. No pulses.
- Reads: prdata = hw_ro_i slice for RO, else the stored register. Sampled combinationally from the current state at completion.
- Writes at the completion edge, for each byte b with pstrb[b]=1:
  - RW: byte = pwdata byte.
  - W1C: bits written 1 are cleared.
- W1C hardware set: every cycle, a W1C bit with hw_set_i=1 becomes 1. Set wins over a simultaneous bus clear.
- pstrb=0 write: completes without error, modifies nothing, still pulses wr_pulse_o.
- hw_regs_o: RO slices = hw_ro_i; others = storage.
- Unreset registers (RESET_MASK=0): use flops with no reset connection. They keep their value across reset and are X after power-up until written.

## Timing
- Reset (asynchronous assert, synchronous deassert by upstream), values until first edge after release:
  - FSM = IDLE, counter = 0.
  - pready = 0, pslverr = 0, prdata = 0, wr_pulse_o = 0, rd_pulse_o = 0.
  - Reset registers = RESET_VALUES.
- Reset mid-transfer aborts it: no write and no pulse.
- Transfer latency: pready rises WAIT_STATES cycles after the first ACCESS cycle. WAIT_STATES=0 gives a 2-cycle transfer (SETUP + ACCESS).
- Write data is visible on hw_regs_o the cycle after the completion edge. wr_pulse_o / rd_pulse_o are high for exactly that one cycle.
- Back-to-back transfers (new SETUP immediately after completion) need no idle cycle.
- A read in the cycle after a write to the same register returns the new value.

## Test plan
- Reset value readback:
  - Stimulus: default parameters; reset, then read reg0..reg7.
  - Required: reg0..reg4 and reg7 return 0,1,1,1,12,0; all with pslverr=0.
  - Required: reg5/reg6 written 0xA5A5A5A5 before a second reset still read 0xA5A5A5A5 after it.
- Byte strobes:
  - Stimulus: write 0xDEADBEEF to reg1 with pstrb=4'b0101.
  - Required: reads 0x00AD00EF, and wr_pulse_o[1] is high for 1 cycle.
- RO and address errors:
  - Stimulus: reg3 set RO with hw_ro_i=0x1234; write to reg3, then read it; NUM_REGS=6 with a read of addr 7.
  - Required: the write gives pslverr=1 and reg3 unchanged; the reg3 read returns 0x1234; the addr 7 read gives pslverr=1 and prdata=0.
- W1C behaviour:
  - Stimulus: reg2 W1C; pulse hw_set_i bits 0 and 5; write 0x1; in the same cycle as a second write of 0x20, assert hw_set_i bit 5.
  - Required: the read after the pulse gives 0x21; the read after writing 0x1 gives 0x20; bit 5 stays 1 after the simultaneous set and clear.
- Wait states and aborts:
  - Stimulus: WAIT_STATES=3; write reg0; separately drop psel during the wait; separately assert reset in ACCESS.
  - Required: pready rises on the 4th ACCESS cycle.
  - Required: the dropped-psel and reset-in-ACCESS transfers cause no write and no pulse, and pready stays 0.
- Back-to-back throughput:
  - Stimulus: write reg4=7 then immediately read reg4, no idle cycle.
  - Required: the read returns 7; total 4 cycles at WAIT_STATES=0.
